mod_counter: RTL
================

Name: mod_counter

Overview:
- Parametrised successor to the fixed 6-bit free-running counter. Supports:
  - configurable width and modulo
  - up/down direction
  - synchronous load and clear
  - wrap or saturate mode
  - a one-shot sweep mode with start/busy/done handshake
- Sequences band/tap/coefficient indices for the 8-band equaliser datapath.
- Its wrap and done pulses frame per-sample processing.

Parameters:
- WIDTH, 6, bit width of the count.
- MODULO, 64, number of count states (2..2^WIDTH); count range is 0..MODULO-1.
- RESET_VALUE, 0, count value after reset; must be < MODULO.
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clk_enable  input  1  count qualifier; no count change when low, except clear/load.
- one_shot  input  1  0 = continuous counting; 1 = sweep only after start.
- start  input  1  one-cycle request to begin a sweep (one_shot=1 only).
- up_down  input  1  1 = count up, 0 = count down.
- clear  input  1  synchronous return to RESET_VALUE.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- current_count  output  WIDTH  registered count.
- wrap_pulse  output  1  registered one-cycle pulse when the count leaves terminal via wrap.
- busy  output  1  high while a one-shot sweep is in progress.
- done  output  1  registered one-cycle pulse at the end of a sweep.

Behaviour:
- Reset: reset is asynchronous and active-low, and the block uses one clock.
  - While rst=0: current_count=RESET_VALUE, wrap_pulse=0, busy=0, done=0, state=IDLE.
  - Release is synchronous to clk.
- Terminal value: MODULO-1 when up_down=1; 0 when up_down=0. Direction is sampled every cycle.
- Priority per rising edge, highest first:
  1. clear
  2. load
  3. count step
- clear: current_count <= RESET_VALUE; state to IDLE; busy=0. It ignores clk_enable, and no done or wrap pulse is produced.
- load: current_count <= min(load_value, MODULO-1). It ignores clk_enable and does not change state.
- Count step: applies only when clk_enable=1 and counting is allowed (one_shot=0, or state=RUN).
  - Not at terminal: step by +1 (up) or -1 (down).
  - At terminal with SATURATE=0: wrap to 0 (up) or MODULO-1 (down), and set wrap_pulse=1 for that one cycle.
  - At terminal with SATURATE=1: hold; wrap_pulse stays 0.
- Counting arithmetic is done at WIDTH+1 bits, so MODULO=2^WIDTH never overflows a comparison.
- One-shot FSM has three states:
  - IDLE: counting is frozen.
    - start=1 → RUN, busy=1 from the next cycle.
    - start while in RUN or DONE is ignored.
  - RUN: counts on enabled cycles.
    - An enabled step taken from the terminal value (wrap, or hold when SATURATE=1) → DONE.
    - The count applies that step as usual, so a wrapping sweep leaves the count at its start point.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - one_shot falling to 0 during RUN → IDLE immediately, with no done pulse.
  - start and clear in the same cycle: clear wins and start is dropped.
- Latency:
  - current_count updates one edge after a qualifying input.
  - wrap_pulse is aligned with the cycle in which the wrapped value appears.
  - done follows the terminal-leaving step by one cycle.
- When one_shot=0, busy and done stay 0.

Decomposition:
- Shared package eq_pkg:
  - FSM state encoding typedef (IDLE, RUN, DONE).
  - Direction constants CNT_UP=1, CNT_DOWN=0.
- Natural sub-module: mod_counter_step. It is combinational next-value logic (step, wrap or saturate, terminal detect, load clamp), reused by the equaliser's address generators.
- The FSM and registers stay in mod_counter.

Test Plan:
- Reset and continuous wrap: defaults, rst low then high, clk_enable=1, up, 70 cycles → count reaches 63 then 0; wrap_pulse high exactly in the cycle count=0 after 63; count=6 after 70 steps.
- Down plus saturate: SATURATE=1, MODULO=10, load 3, up_down=0 → count 2,1,0,0,0; no wrap_pulse ever.
- Load clamp and priority:
  - MODULO=10, load_value=15 → count=9.
  - clear and load asserted together → count=RESET_VALUE.
  - clk_enable low during load → load still applies.
- One-shot sweep: MODULO=8, one_shot=1, start pulse → busy for the 8 enabled steps, count 0..7 then back to 0, done=1 for one cycle, busy=0. A second start mid-sweep is ignored.
- Enable gating: clk_enable toggled 1/0 during RUN → count advances only on enabled cycles; sweep spans 16 clocks for 8 steps.
- Async reset mid-sweep: rst driven low between clock edges at count=4 → count=0, busy=0, done=0 immediately without a clock edge; no done after release.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the equaliser index counters.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-value logic for a modulo counter: step, wrap/saturate,
// terminal detect and load clamp. Reused by the equaliser address generators.
module mod_counter_step
    import eq_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int MODULO   = 64,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] step_value,
    output logic [WIDTH-1:0] load_clamped,
    output logic             at_terminal,
    output logic             wraps
);

    // One extra bit so MODULO = 2^WIDTH still compares correctly.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] term;
    logic [WIDTH:0] nxt;
    logic [WIDTH:0] lv_ext;

    always_comb begin
        cnt_ext     = {1'b0, count};
        lv_ext      = {1'b0, load_value};
        term        = (up_down == CNT_UP) ? LAST : '0;
        at_terminal = (cnt_ext == term);
        wraps       = at_terminal && (SATURATE == 0);
        nxt         = cnt_ext;
        if (!at_terminal) begin
            nxt = (up_down == CNT_UP) ? (cnt_ext + ONE) : (cnt_ext - ONE);
        end else if (SATURATE == 0) begin
            nxt = (up_down == CNT_UP) ? '0 : LAST;
        end
        step_value   = nxt[WIDTH-1:0];
        load_clamped = (lv_ext > LAST) ? LAST[WIDTH-1:0] : load_value;
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter with up/down, load/clear, wrap or saturate,
// and a one-shot sweep handshake framing per-sample equaliser processing.
//
//   state | meaning
//   IDLE  | one-shot counting frozen; waits for start
//   RUN   | sweep in progress, counts on enabled cycles (busy=1)
//   DONE  | sweep finished, done=1 for one cycle
module mod_counter
    import eq_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int MODULO      = 64,
    parameter int RESET_VALUE = 0,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    input  logic             one_shot,
    input  logic             start,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] current_count,
    output logic             wrap_pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    cnt_state_e       state;
    cnt_state_e       state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] load_clamped;
    logic             at_terminal;
    logic             wraps;
    logic             step_en;
    logic             wrap_nxt;

    mod_counter_step #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_step (
        .count        (current_count),
        .up_down      (up_down),
        .load_value   (load_value),
        .step_value   (step_value),
        .load_clamped (load_clamped),
        .at_terminal  (at_terminal),
        .wraps        (wraps)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = current_count;
        wrap_nxt  = 1'b0;
        step_en   = clk_enable && (!one_shot || (state == RUN));
        if (clear) begin
            count_nxt = RST_VAL;
            state_nxt = IDLE;
        end else begin
            if (load) begin
                count_nxt = load_clamped;
            end else if (step_en) begin
                count_nxt = step_value;
                wrap_nxt  = wraps;
            end
            // A load cycle takes no step, so it cannot end a sweep.
            case (state)
                IDLE: if (one_shot && start) state_nxt = RUN;
                RUN: begin
                    if (!one_shot) begin
                        state_nxt = IDLE;
                    end else if (!load && step_en && at_terminal) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            current_count <= RST_VAL;
            wrap_pulse    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            current_count <= count_nxt;
            wrap_pulse    <= wrap_nxt;
            busy          <= (state_nxt == RUN);
            done          <= (state_nxt == DONE);
        end
    end

endmodule
